// File: rtl/result_writer.sv
// Result logger: writes upstream results into a 16x16 memory,
// with indexed readback through the same memory port.
module result_writer #(
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        res_ready,
  input  logic        clear,
  input  logic        rd_req,
  input  logic [3:0]  rd_idx,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic [4:0]  count,
  output logic        wrapped,
  output logic [3:0]  mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [4:0]  count_q, count_d;
  logic        wrapped_q, wrapped_d;
  logic [3:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  rd_idx_q, rd_idx_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_err_q, rd_err_d;

  logic full;
  logic stall;

  assign full  = (count_q == 5'd16);
  assign stall = full & ~WRAP;

  assign res_ready = (state_q == IDLE) & ~clear & ~rd_req & ~stall;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = mem_we_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          wr_ptr_d  = 4'd0;
          count_d   = 5'd0;
          wrapped_d = 1'b0;
        end else if (rd_req) begin
          mem_addr_d = rd_idx;
          rd_idx_d   = rd_idx;
          state_d    = RD_ADDR;
        end else if (res_valid && res_ready) begin
          mem_addr_d = wr_ptr_q;
          mem_data_d = res_data;
          mem_we_d   = 1'b1;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        mem_we_d = 1'b0;
        wr_ptr_d = wr_ptr_q + 4'd1;
        // only reachable when full if overwriting is enabled
        if (full) wrapped_d = 1'b1;
        else      count_d   = count_q + 5'd1;
        state_d = IDLE;
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rd_valid_d = 1'b1;
        if ({1'b0, rd_idx_q} >= count_q) begin
          rd_err_d  = 1'b1;
          rd_data_d = 16'h0000;
        end else begin
          rd_err_d  = 1'b0;
          rd_data_d = mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= 4'd0;
      count_q    <= 5'd0;
      wrapped_q  <= 1'b0;
      mem_addr_q <= 4'd0;
      mem_data_q <= 16'h0000;
      mem_we_q   <= 1'b0;
      rd_idx_q   <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'h0000;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter: WRAP, 1, when 1 a write to a full memory overwrites the oldest entry; when 0 the writer stalls when full.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  reset, asynchronous and active-high.
REQ-004 Port: res_valid  in  1  upstream result valid.
REQ-005 Port: res_data  in  16  upstream result word.
REQ-006 Port: res_ready  out  1  writer accepts res_data this cycle.
REQ-007 Port: clear  in  1  discard all logged results (pointer/count reset; memory contents untouched).
REQ-008 Port: rd_req  in  1  readback request.
REQ-009 Port: rd_idx  in  4  readback slot index.
REQ-010 Port: rd_valid  out  1  one-cycle pulse; rd_data/rd_err valid.
REQ-011 Port: rd_data  out  16  readback word.
REQ-012 Port: rd_err  out  1  readback index not yet written.
REQ-013 Port: count  out  5  number of valid entries, 0..16.
REQ-014 Port: wrapped  out  1  sticky, set on first overwrite.
REQ-015 Port: mem_addr  out  4  to 16x16 result memory address (registered).
REQ-016 Port: mem_data  out  16  to result memory write data (registered).
REQ-017 Port: mem_we  out  1  to result memory write enable (registered).
REQ-018 Port: mem_rdata  in  16  from result memory registered read data (1-cycle read latency).

Function
REQ-019 FSM states IDLE, WRITE, RD_ADDR, RD_DATA; new requests accepted only in IDLE.
REQ-020 res_ready = (state==IDLE) & ~clear & ~rd_req & ~(count==16 & WRAP==0); combinational.
REQ-021 Priority in IDLE: clear > rd_req > res_valid.
REQ-022 clear in IDLE: wr_ptr<=0, count<=0, wrapped<=0 at that edge; stays IDLE; clear outside IDLE ignored.
REQ-023 Write accept (res_valid & res_ready at edge N): mem_addr<=wr_ptr, mem_data<=res_data, mem_we<=1; state WRITE.
REQ-024 WRITE (edge N+1): mem_we<=0, wr_ptr<=wr_ptr+1 mod 16, count<=min(count+1,16), IDLE; throughput one result per 2 cycles.
REQ-025 WRITE with count==16 (WRAP=1 only): wrapped<=1; count stays 16; wr_ptr 15->0 wraps naturally.
REQ-026 Read accept (rd_req in IDLE at edge N, clear low): mem_addr<=rd_idx, latch rd_idx, mem_we stays 0; state RD_ADDR.
REQ-027 RD_ADDR (edge N+1): state RD_DATA; memory samples mem_addr at this edge.
REQ-028 RD_DATA (edge N+2): rd_data<=mem_rdata, rd_valid<=1 for exactly one cycle, IDLE.
REQ-029 rd_err (at edge N+2): 1 and rd_data=0 when latched rd_idx >= count; else 0; any index valid when count==16.
REQ-030 rd_valid deasserts at the edge following its assertion regardless of new requests.
REQ-031 mem_we is never high in RD_ADDR/RD_DATA; read and write never overlap.
REQ-032 res_valid held while res_ready low loses no data; res_data is sampled only on the accept edge.

Reset
REQ-033 rst high asynchronously forces: state IDLE, wr_ptr 0, count 0, wrapped 0, mem_we 0, mem_addr 0, mem_data 0, rd_valid 0, rd_data 0, rd_err 0.
REQ-034 rst mid-WRITE or mid-read aborts immediately; mem_we drops with rst; no rd_valid issued for the aborted read.
REQ-035 First acceptance possible at the first posedge after rst deasserts.

Verification
REQ-036 Write 0x1111,0x2222,0x3333 -> mem_we pulses at addr 0,1,2; count=3; res_ready low in each WRITE cycle.
REQ-037 After REQ-036, rd_req idx=1 at edge N -> rd_valid at edge N+2, rd_data=0x2222, rd_err=0; idx=5 -> rd_data=0, rd_err=1.
REQ-038 WRAP=0, write 16 words -> count=16, res_ready stays low with res_valid high; 17th word not written.
REQ-039 WRAP=1, write 17 words (0x0100+i) -> 17th at addr 0, wrapped=1, count=16; read idx 0 -> 0x0110.
REQ-040 rd_req, res_valid, clear all high in IDLE -> clear wins, count=0, no mem_we, no rd_valid; next cycle rd_req wins over res_valid.
REQ-041 Assert rst during RD_ADDR -> all outputs at reset values, no rd_valid; write after release lands at addr 0.
